axi_stream_upsizer: RTL

AXI_STREAM_UPSIZER -- requirements
Module: axi_stream_upsizer

---
 rtl/axis_width_pkg.sv | 21 ++
 rtl/axi_stream_upsizer_if.sv | 31 +++
 rtl/serial_in_parallel_out.sv | 42 ++++
 rtl/axi_stream_upsizer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/axis_width_pkg.sv
// rtl/axis_width_pkg.sv - shared AXI-Stream width constants and lane-counter sizing
//
// Shared by the upsizer and the downsizer.
// Contents:
//   AXIS_NARROW_W / AXIS_WIDE_W  default narrow and wide data widths
//   RATIO_MIN / RATIO_MAX        legal range of narrow beats per wide beat
//   lane_cnt_w()                 width of a lane counter for a given ratio
package axis_width_pkg;

    localparam int AXIS_NARROW_W = 32;
    localparam int AXIS_WIDE_W   = 64;

    localparam int RATIO_MIN = 2;
    localparam int RATIO_MAX = 8;

    // ceil(log2(ratio)), never less than one bit so RATIO=2 still gets a counter.
    function automatic int lane_cnt_w(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/axi_stream_upsizer_if.sv
// rtl/axi_stream_upsizer_if.sv - AXI-Stream style beat interface used on both sides of the upsizer
//
// Parameter W: TDATA width in bits.
// Signals:
//   TVALID  source -> sink  beat valid
//   TREADY  sink -> source  sink accepts the beat
//   TDATA   source -> sink  beat data, W bits
//   TLAST   source -> sink  end of packet (only when UPSIZER_TLAST_EN is defined)
// Modports: master (drives the stream), slave (receives it).
interface axi_stream_upsizer_if
    import axis_width_pkg::*;
#(
    parameter int W = AXIS_NARROW_W
) ();

    logic         TVALID;
    logic         TREADY;
    logic [W-1:0] TDATA;
`ifdef UPSIZER_TLAST_EN
    logic         TLAST;
`endif

`ifdef UPSIZER_TLAST_EN
    modport master (output TVALID, output TDATA, output TLAST, input TREADY);
    modport slave  (input TVALID, input TDATA, input TLAST, output TREADY);
`else
    modport master (output TVALID, output TDATA, input TREADY);
    modport slave  (input TVALID, input TDATA, output TREADY);
`endif

endinterface

// File: rtl/serial_in_parallel_out.sv
// rtl/serial_in_parallel_out.sv - lane accumulator: writes one narrow beat into a selected lane
//
// Parameters: LANE_W lane width, LANES number of lanes, IDX_W lane index width.
// Ports:
//   clk      clock
//   reset    asynchronous active-low reset, clears all lanes
//   clear    synchronous clear of all lanes (wins over wr_en)
//   wr_en    write wr_data into lane wr_lane
//   wr_lane  target lane index
//   wr_data  beat to store
//   lanes    all lanes, lane 0 in the least significant bits
module serial_in_parallel_out
    import axis_width_pkg::*;
#(
    parameter int LANE_W = AXIS_NARROW_W,
    parameter int LANES  = 1,
    parameter int IDX_W  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_lane,
    input  logic [LANE_W-1:0]       wr_data,
    output logic [LANE_W*LANES-1:0] lanes
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lanes <= '0;
        end else if (clear) begin
            lanes <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_lane == IDX_W'(i)) begin
                    lanes[i*LANE_W +: LANE_W] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/axi_stream_upsizer.sv
// rtl/axi_stream_upsizer.sv - packs RATIO narrow AXI-Stream beats into one wide beat
//
// Optional feature macro: UPSIZER_TLAST_EN (adds narrow/wide TLAST; a TLAST beat
// closes the wide word early with the unused upper lanes zero).
// Parameters: NARROW_W narrow width, RATIO narrow beats per wide beat (2..8).
// Ports:
//   clk     clock, rising edge
//   reset   asynchronous active-low reset
//   narrow  slave stream, NARROW_W bits; lane 0 of a wide word is its first beat
//   wide    master stream, NARROW_W*RATIO bits, driven only from registers
module axi_stream_upsizer
    import axis_width_pkg::*;
#(
    parameter int NARROW_W = AXIS_NARROW_W,
    parameter int RATIO    = AXIS_WIDE_W / AXIS_NARROW_W
) (
    input  logic                 clk,
    input  logic                 reset,
    axi_stream_upsizer_if.slave  narrow,
    axi_stream_upsizer_if.master wide
);

    localparam int WIDE_W = NARROW_W * RATIO;
    localparam int LW     = lane_cnt_w(RATIO);
    localparam int ACC_W  = NARROW_W * (RATIO - 1);

    // Lane counter: value k is the FILL(k) state.
    logic [LW-1:0]     lane_cnt, lane_cnt_next;
    logic              out_valid, out_valid_next;
    logic [WIDE_W-1:0] out_data, out_data_next;
    logic [ACC_W-1:0]  acc_lanes;
    logic [WIDE_W-1:0] word_next;
    logic              acc_wr, acc_clear;
    logic              tlast_in;
    logic              last_lane;
    logic              accept;
    logic              complete;
    logic              wide_fire;

`ifdef UPSIZER_TLAST_EN
    logic out_last, out_last_next;
    assign tlast_in = narrow.TLAST;
`else
    assign tlast_in = 1'b0;
`endif

    assign last_lane = (lane_cnt == LW'(RATIO - 1));
    assign wide_fire = out_valid && wide.TREADY;

    // A word-completing beat needs the output register free (or leaving this
    // cycle); any other beat only lands in the accumulator and never stalls.
    assign narrow.TREADY = !(out_valid && !wide.TREADY && (last_lane || tlast_in));

    assign accept   = narrow.TVALID && narrow.TREADY;
    assign complete = accept && (last_lane || tlast_in);

    // Accumulator lanes at or above the current lane are still zero (it is
    // cleared on every completion), so the current beat can simply be written
    // over its lane and everything above stays zero for a short word.
    always_comb begin
        word_next = {{NARROW_W{1'b0}}, acc_lanes};
        for (int i = 0; i < RATIO; i++) begin
            if (lane_cnt == LW'(i)) begin
                word_next[i*NARROW_W +: NARROW_W] = narrow.TDATA;
            end
        end
    end

    serial_in_parallel_out #(
        .LANE_W (NARROW_W),
        .LANES  (RATIO - 1),
        .IDX_W  (LW)
    ) u_sipo (
        .clk     (clk),
        .reset   (reset),
        .clear   (acc_clear),
        .wr_en   (acc_wr),
        .wr_lane (lane_cnt),
        .wr_data (narrow.TDATA),
        .lanes   (acc_lanes)
    );

    always_comb begin
        lane_cnt_next  = lane_cnt;
        out_valid_next = out_valid;
        out_data_next  = out_data;
`ifdef UPSIZER_TLAST_EN
        out_last_next  = out_last;
`endif
        acc_wr         = 1'b0;
        acc_clear      = 1'b0;

        if (complete) begin
            // Reload wins over a simultaneous wide transfer: no bubble.
            out_data_next  = word_next;
            out_valid_next = 1'b1;
            lane_cnt_next  = '0;
            acc_clear      = 1'b1;
`ifdef UPSIZER_TLAST_EN
            out_last_next  = tlast_in;
`endif
        end else begin
            if (wide_fire) begin
                out_valid_next = 1'b0;
            end
            if (accept) begin
                acc_wr        = 1'b1;
                lane_cnt_next = lane_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef UPSIZER_TLAST_EN
            out_last  <= 1'b0;
`endif
        end else begin
            lane_cnt  <= lane_cnt_next;
            out_valid <= out_valid_next;
            out_data  <= out_data_next;
`ifdef UPSIZER_TLAST_EN
            out_last  <= out_last_next;
`endif
        end
    end

    assign wide.TVALID = out_valid;
    assign wide.TDATA  = out_data;
`ifdef UPSIZER_TLAST_EN
    assign wide.TLAST  = out_last;
`endif

endmodule
